// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract BCD display block: FSM state
// encoding, seven-segment constants and the decimal glyph table.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Active-low segment patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Glyphs for 0..9, index 0 in the least significant slot
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // 10^n, used to check at elaboration that the display fields are wide enough
  function automatic longint pow10(input int n);
    longint acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/addsub_bcd_display_if.sv
// Board-side signal bundle: go button, switches, displays and status.
interface addsub_bcd_display_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
);
  logic                  KEY1;
  logic [2*WIDTH:0]      SW;
  logic [7*DIGITS-1:0]   HEX_A;
  logic [7*DIGITS-1:0]   HEX_B;
  logic [7*DIGITS-1:0]   HEX_R;
  logic [6:0]            HEX_SIGN;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output KEY1, SW,
    input  HEX_A, HEX_B, HEX_R, HEX_SIGN, BUSY, DONE
  );

  modport slave (
    input  KEY1, SW,
    output HEX_A, HEX_B, HEX_R, HEX_SIGN, BUSY, DONE
  );
endinterface

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low seven-segment pattern, with a blank override
// used for leading-zero suppression.
module seg7_decoder
  import addsub_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Select blank, a glyph, or blank for non-decimal codes
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (bcd <= 4'd9) begin
      seg = SEG_GLYPH[bcd];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/addsub_bcd_display.sv
// Adds or subtracts two unsigned switch operands on a button press, converts
// operands and result to BCD with a serial double-dabble, and shows them on
// seven-segment displays with leading-zero blanking and a sign digit.
module addsub_bcd_display
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  addsub_bcd_display_if.slave bus
);

  localparam int RW = WIDTH + 1;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1) + 1;

  if ((WIDTH < 2) || (WIDTH > 12)) begin : g_bad_width
    $error("addsub_bcd_display: WIDTH must be in 2..12");
  end
  if (!(pow10(DIGITS) > longint'((2 ** (WIDTH + 1)) - 2))) begin : g_bad_digits
    $error("addsub_bcd_display: DIGITS too small for result range");
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift left
  function automatic logic [BW+RW-1:0] dabble(input logic [BW-1:0] bcd,
                                               input logic [RW-1:0] bin);
    logic [BW-1:0]    adj;
    logic [BW+RW-1:0] tmp;
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k+:4] >= 4'd5) begin
        adj[4*k+:4] = adj[4*k+:4] + 4'd3;
      end else begin
        adj[4*k+:4] = adj[4*k+:4];
      end
    end
    tmp = {adj, bin};
    return tmp << 1;
  endfunction

  logic             key_meta_r, key_sync_r, key_prev_r;
  logic             go_pulse_s;
  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [RW-1:0]    a_bin_r, b_bin_r, r_bin_r;
  logic [BW-1:0]    a_bcd_r, b_bcd_r, r_bcd_r;
  logic             neg_cap_r;
  logic [BW-1:0]    disp_a_r, disp_b_r, disp_r_r;
  logic [6:0]       hex_sign_r;
  logic             busy_r, done_r;

  logic [WIDTH-1:0] sw_a_s, sw_b_s;
  logic             mode_s;
  logic [RW-1:0]    mag_s;
  logic             neg_s;

  // Bring the asynchronous button into the clock domain and remember last level
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
      key_prev_r <= 1'b1;
    end else begin
      key_meta_r <= bus.KEY1;
      key_sync_r <= key_meta_r;
      key_prev_r <= key_sync_r;
    end
  end

  // A press is a single-cycle falling edge of the synchronized level
  assign go_pulse_s = key_prev_r & ~key_sync_r;

  // Decode switches and compute result magnitude and sign for capture
  always_comb begin
    sw_a_s = bus.SW[2*WIDTH-1:WIDTH];
    sw_b_s = bus.SW[WIDTH-1:0];
    mode_s = bus.SW[2*WIDTH];
    mag_s  = '0;
    neg_s  = 1'b0;
    if (!mode_s) begin
      mag_s = {1'b0, sw_a_s} + {1'b0, sw_b_s};
      neg_s = 1'b0;
    end else if (sw_a_s >= sw_b_s) begin
      mag_s = {1'b0, sw_a_s} - {1'b0, sw_b_s};
      neg_s = 1'b0;
    end else begin
      mag_s = {1'b0, sw_b_s} - {1'b0, sw_a_s};
      neg_s = 1'b1;
    end
  end

  // Control FSM with capture, serial conversion and display update
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      a_bin_r    <= '0;
      b_bin_r    <= '0;
      r_bin_r    <= '0;
      a_bcd_r    <= '0;
      b_bcd_r    <= '0;
      r_bcd_r    <= '0;
      neg_cap_r  <= 1'b0;
      disp_a_r   <= '0;
      disp_b_r   <= '0;
      disp_r_r   <= '0;
      hex_sign_r <= SEG_BLANK;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_pulse_s) begin
            a_bin_r   <= {1'b0, sw_a_s};
            b_bin_r   <= {1'b0, sw_b_s};
            r_bin_r   <= mag_s;
            neg_cap_r <= neg_s;
            cnt_r     <= '0;
            a_bcd_r   <= '0;
            b_bcd_r   <= '0;
            r_bcd_r   <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_CONV;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CONV: begin
          {a_bcd_r, a_bin_r} <= dabble(a_bcd_r, a_bin_r);
          {b_bcd_r, b_bin_r} <= dabble(b_bcd_r, b_bin_r);
          {r_bcd_r, r_bin_r} <= dabble(r_bcd_r, r_bin_r);
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH)) begin
            state_r <= ST_UPDATE;
          end else begin
            state_r <= ST_CONV;
          end
        end
        ST_UPDATE: begin
          disp_a_r   <= a_bcd_r;
          disp_b_r   <= b_bcd_r;
          disp_r_r   <= r_bcd_r;
          hex_sign_r <= neg_cap_r ? SEG_MINUS : SEG_BLANK;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY     = busy_r;
  assign bus.DONE     = done_r;
  assign bus.HEX_SIGN = hex_sign_r;

  // Digit k is blanked when it and every more significant digit are zero;
  // digit 0 is never blanked so a zero value still reads "0".
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic blank_a, blank_b, blank_r;
    if (k == 0) begin : g_lsd
      assign blank_a = 1'b0;
      assign blank_b = 1'b0;
      assign blank_r = 1'b0;
    end else begin : g_upper
      assign blank_a = (disp_a_r[BW-1:4*k] == '0);
      assign blank_b = (disp_b_r[BW-1:4*k] == '0);
      assign blank_r = (disp_r_r[BW-1:4*k] == '0);
    end

    seg7_decoder u_dec_a (
      .bcd   (disp_a_r[4*k+:4]),
      .blank (blank_a),
      .seg   (bus.HEX_A[7*k+:7])
    );
    seg7_decoder u_dec_b (
      .bcd   (disp_b_r[4*k+:4]),
      .blank (blank_b),
      .seg   (bus.HEX_B[7*k+:7])
    );
    seg7_decoder u_dec_r (
      .bcd   (disp_r_r[4*k+:4]),
      .blank (blank_r),
      .seg   (bus.HEX_R[7*k+:7])
    );
  end

endmodule

// File: tb/tb_addsub_bcd_display.sv
// Directed bench for addsub_bcd_display: a WIDTH=4/DIGITS=2 instance and a
// WIDTH=8/DIGITS=3 instance sharing clock and reset.
module tb_addsub_bcd_display;

  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G3 = 7'h30;
  localparam logic [6:0] G5 = 7'h12;
  localparam logic [6:0] G6 = 7'h02;
  localparam logic [6:0] G9 = 7'h10;
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MI = 7'b0111111;

  logic clk;
  logic key0;
  int   checks;
  int   failures;
  int   done_cnt;

  addsub_bcd_display_if #(.WIDTH(4), .DIGITS(2)) bus4 ();
  addsub_bcd_display_if #(.WIDTH(8), .DIGITS(3)) bus8 ();

  addsub_bcd_display #(.WIDTH(4), .DIGITS(2)) dut4 (
    .CLOCK_50 (clk),
    .KEY0     (key0),
    .bus      (bus4.slave)
  );

  addsub_bcd_display #(.WIDTH(8), .DIGITS(3)) dut8 (
    .CLOCK_50 (clk),
    .KEY0     (key0),
    .bus      (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Press KEY1 on the small instance, verify exact latency, one-cycle DONE
  // and the displayed fields, then release the button.
  task automatic run_op(input string tag, input logic [8:0] sw,
                        input logic [13:0] ea, input logic [13:0] eb,
                        input logic [13:0] er, input logic [6:0] es);
    bus4.SW = sw;
    @(negedge clk);
    bus4.KEY1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_done_early"}, 32'(bus4.DONE), 32'd0);
    chk({tag, "_busy"}, 32'(bus4.BUSY), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(bus4.DONE), 32'd1);
    chk({tag, "_hex_a"}, 32'(bus4.HEX_A), 32'(ea));
    chk({tag, "_hex_b"}, 32'(bus4.HEX_B), 32'(eb));
    chk({tag, "_hex_r"}, 32'(bus4.HEX_R), 32'(er));
    chk({tag, "_sign"}, 32'(bus4.HEX_SIGN), 32'(es));
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, 32'(bus4.DONE), 32'd0);
    chk({tag, "_busy_fall"}, 32'(bus4.BUSY), 32'd0);
    bus4.KEY1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    key0      = 1'b0;
    bus4.KEY1 = 1'b1;
    bus4.SW   = '0;
    bus8.KEY1 = 1'b1;
    bus8.SW   = '0;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex_a", 32'(bus4.HEX_A), 32'({BL, G0}));
    chk("rst_hex_b", 32'(bus4.HEX_B), 32'({BL, G0}));
    chk("rst_hex_r", 32'(bus4.HEX_R), 32'({BL, G0}));
    chk("rst_sign", 32'(bus4.HEX_SIGN), 32'(BL));
    chk("rst_busy", 32'(bus4.BUSY), 32'd0);
    chk("rst_done", 32'(bus4.DONE), 32'd0);
    chk("rst8_hex_r", 32'(bus8.HEX_R), 32'({BL, BL, G0}));
    key0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 9 + 6 = 15
    run_op("add_9_6", {1'b0, 4'd9, 4'd6}, {BL, G9}, {BL, G6}, {G1, G5}, BL);
    // 3 - 12 = -9
    run_op("sub_3_12", {1'b1, 4'd3, 4'd12}, {BL, G3}, {G1, G2}, {BL, G9}, MI);
    // 5 - 5 = 0, not negative
    run_op("sub_5_5", {1'b1, 4'd5, 4'd5}, {BL, G5}, {BL, G5}, {BL, G0}, BL);
    // 15 + 15 = 30
    run_op("add_15_15", {1'b0, 4'd15, 4'd15}, {G1, G5}, {G1, G5}, {G3, G0}, BL);

    // Button held 50 cycles, switches changed mid-conversion: 2 + 3 = 5
    bus4.SW = {1'b0, 4'd2, 4'd3};
    done_cnt = 0;
    @(negedge clk);
    bus4.KEY1 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus4.DONE) done_cnt++;
      if (i == 5) bus4.SW = {1'b1, 4'd7, 4'd1};
      if (i == 50) bus4.KEY1 = 1'b1;
    end
    chk("hold_done_count", 32'(done_cnt), 32'd1);
    chk("hold_hex_r", 32'(bus4.HEX_R), 32'({BL, G5}));
    chk("hold_hex_a", 32'(bus4.HEX_A), 32'({BL, G2}));
    chk("hold_sign", 32'(bus4.HEX_SIGN), 32'(BL));

    // Second press while busy is ignored: 1 + 1 = 2
    bus4.SW = {1'b0, 4'd1, 4'd1};
    done_cnt = 0;
    @(negedge clk);
    bus4.KEY1 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus4.DONE) done_cnt++;
      if (i == 4) bus4.KEY1 = 1'b1;
      if (i == 5) bus4.KEY1 = 1'b0;
      if (i == 15) bus4.KEY1 = 1'b1;
    end
    chk("repress_done_count", 32'(done_cnt), 32'd1);
    chk("repress_hex_r", 32'(bus4.HEX_R), 32'({BL, G2}));

    // Reset on the third conversion cycle aborts without DONE
    bus4.SW = {1'b0, 4'd9, 4'd9};
    @(negedge clk);
    bus4.KEY1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    key0      = 1'b0;
    bus4.KEY1 = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(bus4.BUSY), 32'd0);
    chk("abort_done", 32'(bus4.DONE), 32'd0);
    chk("abort_hex_r", 32'(bus4.HEX_R), 32'({BL, G0}));
    chk("abort_hex_a", 32'(bus4.HEX_A), 32'({BL, G0}));
    key0 = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (bus4.DONE) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_hold_hex_r", 32'(bus4.HEX_R), 32'({BL, G0}));
    chk("abort_hold_sign", 32'(bus4.HEX_SIGN), 32'(BL));

    // Wide instance: 255 + 255 = 510, latency 13 edges
    bus8.SW = {1'b0, 8'd255, 8'd255};
    @(negedge clk);
    bus8.KEY1 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("w8_done_early", 32'(bus8.DONE), 32'd0);
    @(posedge clk);
    #1;
    chk("w8_done", 32'(bus8.DONE), 32'd1);
    chk("w8_hex_r", 32'(bus8.HEX_R), 32'({G5, G1, G0}));
    chk("w8_hex_a", 32'(bus8.HEX_A), 32'({G2, G5, G5}));
    chk("w8_sign", 32'(bus8.HEX_SIGN), 32'(BL));
    bus8.KEY1 = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
